// File: rtl/csr_bank_pkg.sv
// csr_bank_pkg: shared definitions for the CSR bank.
//   - register indices of the map (CU index / AXI byte address >> 2)
//   - CONTROL and STATUS bit positions
//   - AXI response codes
//   - arithmetic precision encodings and the chain flag
//   - FSM state enums for the AXI4-Lite slave
//   - helpers that classify a register index as readable / writable
package csr_bank_pkg;

    // Precision encodings held in ARITHMETIC_PRECISION[LOG_ALLOWED_PRECISIONS-1:0]
    localparam int         LOG_ALLOWED_PRECISIONS = 3;
    localparam logic [2:0] PREC_INT8              = 3'd0;
    localparam logic [2:0] PREC_INT16             = 3'd1;
    localparam logic [2:0] PREC_INT32             = 3'd2;
    localparam logic [2:0] PREC_FP16              = 3'd3;
    localparam logic [2:0] PREC_FP32              = 3'd4;
    localparam logic [2:0] NO_COMPUTATION         = 3'd7;

    // Chain flag in ARITHMETIC_PRECISION[7]
    localparam int   PREC_CHAIN_BIT = 7;
    localparam logic NO_CHAIN       = 1'b0;
    localparam logic CHAIN          = 1'b1;

    // Register indices
    localparam logic [31:0] A_ARITHMETIC_PRECISION = 32'd0;
    localparam logic [31:0] A_FP_MODE              = 32'd1;
    localparam logic [31:0] A_CONTROL              = 32'd2;
    localparam logic [31:0] A_STATUS               = 32'd3;
    localparam int          NUM_MAP_REGS           = 4;

    // CONTROL bits
    localparam int CTRL_START      = 0;
    localparam int CTRL_CONTINUE   = 1;
    localparam int CTRL_GLB_ENABLE = 2;

    // STATUS bits
    localparam int STATUS_IDLE  = 0;
    localparam int STATUS_READY = 1;
    localparam int STATUS_DONE  = 2;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Writable bits of each RW register; everything else reads back 0.
    // Precision mask covers bits [LOG_ALLOWED_PRECISIONS-1:0] plus the chain bit.
    localparam logic [7:0] PREC_WR_MASK = 8'h87;
    localparam logic [7:0] FP_WR_MASK   = 8'h03;
    localparam logic [7:0] CTRL_WR_MASK = 8'h07;
    localparam logic [7:0] PREC_DEFAULT = {NO_CHAIN, 4'b0000, NO_COMPUTATION};

    typedef enum logic { W_IDLE, W_RESP } wr_state_e;
    typedef enum logic { R_IDLE, R_DATA } rd_state_e;

    function automatic logic idx_readable(input logic [31:0] idx, input int num_regs);
        return idx < 32'(num_regs);
    endfunction

    // STATUS is read-only, so a write to it is an error just like a hole in the map
    function automatic logic idx_writable(input logic [31:0] idx, input int num_regs);
        return (idx < 32'(num_regs)) && (idx != A_STATUS);
    endfunction

endpackage

// File: rtl/csr_bank_axil.sv
// axil_slave_if: AXI4-Lite slave front end for the CSR bank.
// Holds the independent write and read FSMs and turns AXI traffic into a
// simple register-access interface:
//   wr_en/wr_idx/wr_data : one-cycle write strobe (only when wstrb[0] is set)
//   wr_err               : core says wr_idx is not writable -> SLVERR
//   rd_en/rd_idx         : one-cycle pulse when a read address is accepted
//   rd_data/rd_err       : combinational register value / invalid-index flag
// Handshake rule on every channel: a beat transfers on a rising clk edge where
// both valid and ready are high; a valid, once raised by this block, stays high
// with stable payload until that edge. All readies/valids are low while reset=0.
module axil_slave_if
    import csr_bank_pkg::*;
#(
    parameter int REG_WIDTH      = 8,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,
    output logic                          wr_en,
    output logic [AXI_ADDR_WIDTH-3:0]     wr_idx,
    output logic [REG_WIDTH-1:0]          wr_data,
    input  logic                          wr_err,
    output logic                          rd_en,
    output logic [AXI_ADDR_WIDTH-3:0]     rd_idx,
    input  logic [REG_WIDTH-1:0]          rd_data,
    input  logic                          rd_err
);

    wr_state_e w_state_q, w_state_d;
    rd_state_e r_state_q, r_state_d;

    logic                      aw_got_q, w_got_q;
    logic [AXI_ADDR_WIDTH-3:0] aw_idx_q;
    logic [REG_WIDTH-1:0]      w_data_q;
    logic                      w_strb_q;
    logic                      aw_hs, w_hs, ar_hs, wr_commit, cur_strb;

    assign s_axi_awready = reset && (w_state_q == W_IDLE) && !aw_got_q;
    assign s_axi_wready  = reset && (w_state_q == W_IDLE) && !w_got_q;
    assign s_axi_arready = reset && (r_state_q == R_IDLE);

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    // The write happens in the cycle the second of the two beats arrives
    // (or both together), using the latched copy of whichever came first.
    assign wr_commit = reset && (w_state_q == W_IDLE)
                     && (aw_got_q || aw_hs) && (w_got_q || w_hs);

    assign wr_idx   = aw_got_q ? aw_idx_q : s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
    assign wr_data  = w_got_q ? w_data_q : s_axi_wdata[REG_WIDTH-1:0];
    assign cur_strb = w_got_q ? w_strb_q : s_axi_wstrb[0];
    assign wr_en    = wr_commit && cur_strb;

    assign rd_en  = ar_hs;
    assign rd_idx = s_axi_araddr[AXI_ADDR_WIDTH-1:2];

    always_ff @(posedge clk) begin
        if (!reset) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        w_state_d    = w_state_q;
        r_state_d    = r_state_q;
        s_axi_bvalid = 1'b0;
        s_axi_rvalid = 1'b0;
        case (w_state_q)
            W_IDLE: if (wr_commit) w_state_d = W_RESP;
            W_RESP: begin
                s_axi_bvalid = reset;
                if (s_axi_bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        case (r_state_q)
            R_IDLE: if (ar_hs) r_state_d = R_DATA;
            R_DATA: begin
                s_axi_rvalid = reset;
                if (s_axi_rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            aw_idx_q    <= '0;
            w_data_q    <= '0;
            w_strb_q    <= 1'b0;
            s_axi_bresp <= RESP_OKAY;
            s_axi_rdata <= '0;
            s_axi_rresp <= RESP_OKAY;
        end else begin
            if (wr_commit) begin
                aw_got_q    <= 1'b0;
                w_got_q     <= 1'b0;
                s_axi_bresp <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_got_q <= 1'b1;
                    aw_idx_q <= s_axi_awaddr[AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_got_q  <= 1'b1;
                    w_data_q <= s_axi_wdata[REG_WIDTH-1:0];
                    w_strb_q <= s_axi_wstrb[0];
                end
            end
            if (ar_hs) begin
                s_axi_rdata <= rd_err ? '0 : AXI_DATA_WIDTH'(rd_data);
                s_axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Byte-lane offset bits, upper strobes and upper data bits carry no meaning here
    logic unused_axi_bits;
    assign unused_axi_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0],
                               s_axi_wstrb[AXI_DATA_WIDTH/8-1:1],
                               s_axi_wdata[AXI_DATA_WIDTH-1:REG_WIDTH]};

endmodule

// File: rtl/csr_bank.sv
// csr_bank: control/status register file between the AXI interconnect (PS)
// and the DTPU control unit (CU).
//   clk, reset          : clock, synchronous active-low reset
//   csr_ce/csr_address  : CU read port; csr_dout is registered, holds when csr_ce=0
//   csr_we              : CU write request, accepted and ignored
//   csr_reset           : synchronous clear of the RW registers and sticky status
//   cs_start/cs_continue/glb_enable : control levels/pulse to the CU (CONTROL reg)
//   cs_idle/cs_ready/cs_done        : CU status inputs (STATUS reg)
//   s_axi_*             : AXI4-Lite slave, register index = byte address >> 2
module csr_bank
    import csr_bank_pkg::*;
#(
    parameter int DATA_WIDTH_CSR   = 8,
    parameter int ADDRESS_SIZE_CSR = 32,
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int S_AXI_ADDR_WIDTH = 6,
    parameter int NUM_REGS         = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          csr_ce,
    input  logic                          csr_we,
    input  logic [ADDRESS_SIZE_CSR-1:0]   csr_address,
    output logic [DATA_WIDTH_CSR-1:0]     csr_dout,
    input  logic                          csr_reset,
    output logic                          cs_start,
    output logic                          cs_continue,
    output logic                          glb_enable,
    input  logic                          cs_idle,
    input  logic                          cs_ready,
    input  logic                          cs_done,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int DW    = DATA_WIDTH_CSR;
    localparam int IDX_W = S_AXI_ADDR_WIDTH - 2;

    logic             wr_en, wr_err, rd_en, rd_err;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [DW-1:0]    wr_data, rd_data;
    logic [31:0]      wr_idx32, rd_idx32, cu_idx32;

    logic [DW-1:0] prec_q, fp_q, ctrl_q, status_val, cu_val;
    logic          ready_q, done_q, do_write, status_rd_clr;
    logic [DW-1:0] map_val [NUM_MAP_REGS];

    axil_slave_if #(
        .REG_WIDTH      (DW),
        .AXI_DATA_WIDTH (S_AXI_DATA_WIDTH),
        .AXI_ADDR_WIDTH (S_AXI_ADDR_WIDTH)
    ) u_axil (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .wr_en         (wr_en),
        .wr_idx        (wr_idx),
        .wr_data       (wr_data),
        .wr_err        (wr_err),
        .rd_en         (rd_en),
        .rd_idx        (rd_idx),
        .rd_data       (rd_data),
        .rd_err        (rd_err)
    );

    assign wr_idx32 = 32'(wr_idx);
    assign rd_idx32 = 32'(rd_idx);
    assign cu_idx32 = 32'(csr_address);

    assign wr_err   = !idx_writable(wr_idx32, NUM_REGS);
    assign rd_err   = !idx_readable(rd_idx32, NUM_REGS);
    assign do_write = wr_en && !wr_err;

    // Sticky bits clear on the cycle the AXI read address of STATUS is accepted;
    // the read data is captured on that same edge, so it still sees them set.
    assign status_rd_clr = rd_en && (rd_idx32 == A_STATUS);

    always_comb begin
        status_val               = '0;
        status_val[STATUS_IDLE]  = cs_idle;
        status_val[STATUS_READY] = ready_q;
        status_val[STATUS_DONE]  = done_q;
    end

    always_comb begin
        map_val[A_ARITHMETIC_PRECISION[1:0]] = prec_q;
        map_val[A_FP_MODE[1:0]]              = fp_q;
        map_val[A_CONTROL[1:0]]              = ctrl_q;
        map_val[A_STATUS[1:0]]               = status_val;
    end

    assign rd_data = map_val[rd_idx32[1:0]];
    assign cu_val  = idx_readable(cu_idx32, NUM_REGS) ? map_val[cu_idx32[1:0]] : '0;

    // RW registers. Priority: reset > csr_reset > AXI write > cs_done clearing
    // start / continue self-clear.
    always_ff @(posedge clk) begin
        if (!reset || csr_reset) begin
            prec_q <= DW'(PREC_DEFAULT);
            fp_q   <= '0;
            ctrl_q <= '0;
        end else begin
            ctrl_q[CTRL_CONTINUE] <= 1'b0;
            if (cs_done) ctrl_q[CTRL_START] <= 1'b0;
            if (do_write) begin
                case (wr_idx32)
                    A_ARITHMETIC_PRECISION: prec_q <= wr_data & DW'(PREC_WR_MASK);
                    A_FP_MODE:              fp_q   <= wr_data & DW'(FP_WR_MASK);
                    A_CONTROL:              ctrl_q <= wr_data & DW'(CTRL_WR_MASK);
                    default: ;
                endcase
            end
        end
    end

    // Sticky status: a set coinciding with the read-clear wins
    always_ff @(posedge clk) begin
        if (!reset || csr_reset) begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            if (status_rd_clr) begin
                ready_q <= 1'b0;
                done_q  <= 1'b0;
            end
            if (cs_ready) ready_q <= 1'b1;
            if (cs_done)  done_q  <= 1'b1;
        end
    end

    // CU read port; csr_reset deliberately does not touch it
    always_ff @(posedge clk) begin
        if (!reset) begin
            csr_dout <= '0;
        end else if (csr_ce) begin
            csr_dout <= cu_val;
        end
    end

    assign cs_start    = ctrl_q[CTRL_START];
    assign cs_continue = ctrl_q[CTRL_CONTINUE];
    assign glb_enable  = ctrl_q[CTRL_GLB_ENABLE];

    logic unused_csr_we;
    assign unused_csr_we = csr_we;

endmodule
